// File: rtl/irb_readback_pkg.sv
// Shared IRB readback constants, FSM state encoding and FIFO entry type.
// Also used by the LCD_CTRL side for frame geometry.
package irb_readback_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int N_PIX  = 64;
    localparam int SUM_W  = 14;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pix_t;

endpackage

// File: rtl/irb_readback_fifo2.sv
// Two-entry {addr,data} FIFO between IRB read return and the output channel.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i, rdata_o (head), count_o, empty_o.
module irb_rd_fifo2
    import irb_readback_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  pix_t       wdata_i,
    input  logic       pop_i,
    output pix_t       rdata_o,
    output logic [1:0] count_o,
    output logic       empty_o
);

    pix_t       mem_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            // Push on full with pop overwrites the slot being popped this cycle.
            if (push_i) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) begin
                rp_q <= ~rp_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rp_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/irb_readback.sv
// Reads the 64-pixel image buffer after a done pulse and streams it out with a running sum.
// Ports: clk, reset (async low), start, IRB_CEN/IRB_RW/IRB_A/IRB_Q, busy,
//        out_valid/out_ready/out_data/out_addr, fin (1-cycle), sum.
module irb_readback
    import irb_readback_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              IRB_CEN,
    output logic              IRB_RW,
    output logic [ADDR_W-1:0] IRB_A,
    input  logic [DATA_W-1:0] IRB_Q,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              fin,
    output logic [SUM_W-1:0]  sum
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [SUM_W-1:0]   sum_q, sum_d;

    logic [1:0] fifo_count;
    logic       fifo_empty;
    pix_t       head;
    pix_t       wpix;
    logic       hs;
    logic       credit_ok;
    logic       inflight;

    // Read data lands in the FIFO on the edge closing the issue cycle, so the
    // only outstanding read is the one being issued now. A pop this cycle
    // frees a slot for it.
    assign hs        = out_valid && out_ready;
    assign credit_ok = (fifo_count - {1'b0, hs}) < 2'd2;
    assign inflight  = (state_q == READ) && credit_ok;

    assign IRB_CEN = ~inflight;
    assign IRB_RW  = 1'b1;
    assign IRB_A   = rd_addr_q;

    assign wpix = '{addr: rd_addr_q, data: IRB_Q};

    irb_rd_fifo2 u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (inflight),
        .wdata_i (wpix),
        .pop_i   (hs),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head.data;
    assign out_addr  = head.addr;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        sum_d     = sum_q;
        if (hs) begin
            sum_d = sum_q + SUM_W'(head.data);
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                    sum_d     = '0;
                end
            end
            READ: begin
                if (inflight) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Last handshake empties the FIFO; no reads issue here.
                if (hs && fifo_count == 2'd1 && !inflight) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            sum_q     <= sum_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign fin  = (state_q == FIN);
    assign sum  = sum_q;

endmodule
